// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction prefetcher.
//   - Default widths and depths used as parameter defaults by the top.
//   - fetch_entry_t: one prefetched instruction together with the address it came from.
//   - fetch_state_t: issue state of the prefetcher (RUN issuing, HOLD paused).
package fetch_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 32;
    localparam int DEPTH_DEF   = 4;
    localparam int MEM_LAT_DEF = 1;

    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [ADDR_W_DEF-1:0]  addr;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with push/pop/flush, used as the prefetch buffer.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-low
//   i_push   write i_wdata at the tail
//   i_pop    drop the head entry (ignored when empty)
//   i_flush  discard all contents (wins over push/pop)
//   i_wdata  entry to write
//   o_rdata  head entry, visible combinationally
//   o_count  number of stored entries
//   o_empty  no entries stored
//   o_full   DEPTH entries stored
module sync_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;
    logic w_wr_en;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_wr_en   = rst && !i_flush && w_do_push;

    // The head must be visible in the cycle after it lands, so the read is
    // taken straight from the array rather than through an output register.
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

endmodule

// File: rtl/instruction_prefetcher.sv
// Instruction prefetcher: streams instructions from a synchronous ROM into a
// prefetch FIFO and hands them to the decoder with a valid/ready handshake.
// A redirect (parallelFlag) reloads the PC and flushes every stale fetch.
// Ports:
//   clk                rising-edge clock
//   rst                synchronous reset, active-low
//   fetchEnable        1 = issue ROM reads; in-flight reads land regardless
//   parallelFlag       redirect request, sampled each cycle
//   parallelAddress    redirect target
//   memRead            ROM read strobe
//   memAddress         ROM read address (current PC)
//   memData            ROM data, valid MEM_LAT cycles after memRead
//   readyFlag          instructionOutput valid
//   instrReady         consumer accepts this cycle
//   instructionOutput  head-of-FIFO instruction (0 when empty)
//   instrAddress       fetch address of the head instruction (0 when empty)
module instruction_prefetcher
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                INSTR_W    = INSTR_W_DEF,
    parameter int                DEPTH      = DEPTH_DEF,
    parameter int                MEM_LAT    = MEM_LAT_DEF,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetchEnable,
    input  logic               parallelFlag,
    input  logic [ADDR_W-1:0]  parallelAddress,
    output logic               memRead,
    output logic [ADDR_W-1:0]  memAddress,
    input  logic [INSTR_W-1:0] memData,
    output logic               readyFlag,
    input  logic               instrReady,
    output logic [INSTR_W-1:0] instructionOutput,
    output logic [ADDR_W-1:0]  instrAddress
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int SUM_W   = $clog2(DEPTH + MEM_LAT + 1) + 1;
    localparam int ENTRY_W = INSTR_W + ADDR_W;

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [ADDR_W-1:0] r_pc;
    logic              r_pipe_valid [MEM_LAT];
    logic [ADDR_W-1:0] r_pipe_addr  [MEM_LAT];
    logic              w_valid_next [MEM_LAT];
    logic [ADDR_W-1:0] w_addr_next  [MEM_LAT];

    logic [SUM_W-1:0]   w_inflight;
    logic               w_credit_ok;
    logic               w_can_run;
    logic               w_issue;
    logic               w_land;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_fifo_wdata;
    logic [ENTRY_W-1:0] w_fifo_rdata;
    logic [CNT_W-1:0]   w_fifo_count;
    logic               w_fifo_empty;
    logic               w_fifo_full;

    // Reads already issued but not yet landed still need a FIFO slot, so they
    // are counted against the credit together with the stored entries.
    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < MEM_LAT; k++) begin
            w_inflight = w_inflight + SUM_W'(r_pipe_valid[k]);
        end
    end

    assign w_credit_ok = (SUM_W'(w_fifo_count) + w_inflight) < SUM_W'(DEPTH);
    assign w_can_run   = rst && fetchEnable && !parallelFlag && w_credit_ok;

    // Issue decision and RUN/HOLD tracking. A redirect is a one-cycle action:
    // no read that cycle, and the next cycle starts from RUN again.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            RUN: begin
                w_issue = w_can_run;
                if (!w_can_run) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                w_issue = w_can_run;
                if (w_can_run) begin
                    w_state_next = RUN;
                end
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
        if (parallelFlag) begin
            w_state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc <= START_ADDR;
        end else if (parallelFlag) begin
            r_pc <= parallelAddress;
        end else if (w_issue) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    // Latency pipe: stage 0 records the read issued this cycle; the last
    // stage lines up with memData coming back from the ROM.
    genvar gi;
    generate
        for (gi = 0; gi < MEM_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign w_valid_next[gi] = w_issue;
                assign w_addr_next[gi]  = r_pc;
            end else begin : g_tail
                assign w_valid_next[gi] = r_pipe_valid[gi-1];
                assign w_addr_next[gi]  = r_pipe_addr[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst || parallelFlag) begin
            for (int k = 0; k < MEM_LAT; k++) begin
                r_pipe_valid[k] <= 1'b0;
                r_pipe_addr[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < MEM_LAT; k++) begin
                r_pipe_valid[k] <= w_valid_next[k];
                r_pipe_addr[k]  <= w_addr_next[k];
            end
        end
    end

    // Data returning during a redirect belongs to the old stream and is dropped.
    assign w_land       = r_pipe_valid[MEM_LAT-1];
    assign w_push       = w_land && !parallelFlag;
    assign w_pop        = readyFlag && instrReady;
    assign w_fifo_wdata = {memData, r_pipe_addr[MEM_LAT-1]};

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (parallelFlag),
        .i_wdata (w_fifo_wdata),
        .o_rdata (w_fifo_rdata),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // The credit check must make an overflowing push impossible.
    assert property (@(posedge clk) disable iff (!rst)
                     !(w_push && w_fifo_full && !w_pop));

    assign memRead           = w_issue;
    assign memAddress        = r_pc;
    assign readyFlag         = !w_fifo_empty;
    assign instructionOutput = readyFlag ? w_fifo_rdata[ENTRY_W-1:ADDR_W] : '0;
    assign instrAddress      = readyFlag ? w_fifo_rdata[ADDR_W-1:0] : '0;

endmodule

// File: tb/tb_instruction_prefetcher.sv
module tb_instruction_prefetcher;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetchEnable = 1'b0;
    logic        parallelFlag = 1'b0;
    logic [7:0]  parallelAddress = 8'h00;
    logic        memRead;
    logic [7:0]  memAddress;
    logic [31:0] memData = 32'h0;
    logic        readyFlag;
    logic        instrReady = 1'b0;
    logic [31:0] instructionOutput;
    logic [7:0]  instrAddress;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    instruction_prefetcher #(
        .ADDR_W(8), .INSTR_W(32), .DEPTH(4), .MEM_LAT(1), .START_ADDR(8'h00)
    ) dut (
        .clk(clk), .rst(rst), .fetchEnable(fetchEnable),
        .parallelFlag(parallelFlag), .parallelAddress(parallelAddress),
        .memRead(memRead), .memAddress(memAddress), .memData(memData),
        .readyFlag(readyFlag), .instrReady(instrReady),
        .instructionOutput(instructionOutput), .instrAddress(instrAddress)
    );

    // ROM: mem[i] = 0xA5000000 | i, one cycle read latency.
    always @(posedge clk) begin
        if (memRead) memData <= 32'hA5000000 | {24'h0, memAddress};
    end

    // Reference model: queue-level view of PC, FIFO contents and reads in flight.
    logic [7:0]   m_pc = 8'h00;
    fetch_entry_t m_fifo[$];
    logic [7:0]   m_infl[$];
    logic [7:0]   m_acc[$];
    logic [7:0]   d_acc[$];
    int           d_reads = 0;

    function automatic bit m_issue();
        return rst && fetchEnable && !parallelFlag && ((m_fifo.size() + m_infl.size()) < 4);
    endfunction

    function automatic logic [49:0] exp_vec();
        fetch_entry_t h;
        h = '0;
        if (m_fifo.size() > 0) h = m_fifo[0];
        return {m_issue(), m_pc, (m_fifo.size() > 0), h.addr, h.instr};
    endfunction

    function automatic logic [49:0] dut_vec();
        return {memRead, memAddress, readyFlag, instrAddress, instructionOutput};
    endfunction

    task automatic model_step();
        bit iss;
        fetch_entry_t e;
        if (!rst) begin
            m_pc = 8'h00;
            m_fifo.delete();
            m_infl.delete();
            return;
        end
        iss = m_issue();
        if (m_fifo.size() > 0 && instrReady) begin
            m_acc.push_back(m_fifo[0].addr);
            void'(m_fifo.pop_front());
        end
        if (parallelFlag) begin
            m_fifo.delete();
            m_infl.delete();
            m_pc = parallelAddress;
        end else begin
            foreach (m_infl[k]) begin
                e.instr = 32'hA5000000 | {24'h0, m_infl[k]};
                e.addr  = m_infl[k];
                m_fifo.push_back(e);
            end
            m_infl.delete();
            if (iss) begin
                m_infl.push_back(m_pc);
                m_pc = m_pc + 8'h01;
            end
        end
    endtask

    // One clock: observe transfers/reads mid-cycle, advance model on the edge.
    task automatic tick();
        @(negedge clk);
        if (rst && readyFlag && instrReady) d_acc.push_back(instrAddress);
        if (memRead) d_reads++;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; fetchEnable = 1'b0; parallelFlag = 1'b0; instrReady = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        m_acc.delete();
        d_acc.delete();
        d_reads = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0; fetchEnable = 1'b1; instrReady = 1'b1;
        repeat (3) tick();
        n_total++;
        if ({readyFlag, memRead, memAddress} !== 10'h0)
            $display("FAIL reset_outputs: got %h expected %h", {readyFlag, memRead, memAddress}, 10'h0);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if ({memRead, memAddress} !== {1'b1, 8'h00})
            $display("FAIL first_read: got %h expected %h", {memRead, memAddress}, {1'b1, 8'h00});
        else n_pass++;
        d_acc.delete(); m_acc.delete(); d_reads = 0;
        tick();
        tick();
        n_total++;
        if ({readyFlag, instrAddress, instructionOutput} !== {1'b1, 8'h00, 32'hA5000000})
            $display("FAIL first_instr: got %h expected %h",
                     {readyFlag, instrAddress, instructionOutput}, {1'b1, 8'h00, 32'hA5000000});
        else n_pass++;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_total++;
            if (dut_vec() !== exp_vec()) $display("FAIL stream_c%0d: got %h expected %h", c, dut_vec(), exp_vec());
            else n_pass++;
        end
        for (int k = 0; k < d_acc.size(); k++) begin
            n_total++;
            if (d_acc[k] !== 8'(k)) $display("FAIL stream_order_%0d: got %h expected %h", k, d_acc[k], 8'(k));
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fetchEnable = 1'b1; instrReady = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_total++;
            if (dut_vec() !== exp_vec()) $display("FAIL bp_hold_c%0d: got %h expected %h", c, dut_vec(), exp_vec());
            else n_pass++;
        end
        n_total++;
        if (d_reads !== 4) $display("FAIL bp_reads: got %0d expected %0d", d_reads, 4);
        else n_pass++;
        n_total++;
        if ({readyFlag, instructionOutput} !== {1'b1, 32'hA5000000})
            $display("FAIL bp_head: got %h expected %h", {readyFlag, instructionOutput}, {1'b1, 32'hA5000000});
        else n_pass++;
        instrReady = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_total++;
            if (dut_vec() !== exp_vec()) $display("FAIL bp_drain_c%0d: got %h expected %h", c, dut_vec(), exp_vec());
            else n_pass++;
        end
        n_total++;
        if (d_acc.size() < 8) $display("FAIL bp_count: got %0d expected at least %0d", d_acc.size(), 8);
        else n_pass++;
        for (int k = 0; k < d_acc.size(); k++) begin
            n_total++;
            if (d_acc[k] !== 8'(k)) $display("FAIL bp_order_%0d: got %h expected %h", k, d_acc[k], 8'(k));
            else n_pass++;
        end
    endtask

    task automatic test_redirect();
        int idx;
        do_reset();
        fetchEnable = 1'b1; instrReady = 1'b1;
        repeat (6) tick();
        parallelFlag = 1'b1; parallelAddress = 8'h40;
        tick();
        n_total++;
        if (memRead !== 1'b0) $display("FAIL redir_noread: got %b expected %b", memRead, 1'b0);
        else n_pass++;
        parallelFlag = 1'b0;
        idx = d_acc.size();
        for (int c = 0; c < 8; c++) begin
            tick();
            n_total++;
            if (dut_vec() !== exp_vec()) $display("FAIL redir_c%0d: got %h expected %h", c, dut_vec(), exp_vec());
            else n_pass++;
        end
        n_total++;
        if (d_acc.size() <= idx) $display("FAIL redir_none: got %0d expected more than %0d", d_acc.size(), idx);
        else n_pass++;
        for (int k = idx; k < d_acc.size(); k++) begin
            n_total++;
            if (d_acc[k] !== 8'h40 + 8'(k - idx))
                $display("FAIL redir_order_%0d: got %h expected %h", k, d_acc[k], 8'h40 + 8'(k - idx));
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fetchEnable = 1'b1; instrReady = 1'b1;
        repeat (4) tick();
        parallelFlag = 1'b1; parallelAddress = 8'h10;
        tick();
        parallelAddress = 8'h20;
        tick();
        parallelFlag = 1'b0;
        m_acc.delete(); d_acc.delete();
        repeat (5) tick();
        n_total++;
        if (d_acc.size() < 2 || d_acc[0] !== 8'h20 || d_acc[1] !== 8'h21)
            $display("FAIL b2b_last_wins: got %0d entries first %h expected first %h", d_acc.size(),
                     (d_acc.size() > 0) ? d_acc[0] : 8'hXX, 8'h20);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        fetchEnable = 1'b1; instrReady = 1'b0;
        tick();
        tick();
        n_total++;
        if ({readyFlag, instrAddress} !== {1'b1, 8'h00})
            $display("FAIL simul_pre: got %h expected %h", {readyFlag, instrAddress}, {1'b1, 8'h00});
        else n_pass++;
        instrReady = 1'b1; parallelFlag = 1'b1; parallelAddress = 8'h80;
        tick();
        parallelFlag = 1'b0;
        n_total++;
        if (readyFlag !== 1'b0) $display("FAIL simul_empty: got %b expected %b", readyFlag, 1'b0);
        else n_pass++;
        n_total++;
        if (d_acc.size() != 1 || d_acc[0] !== 8'h00)
            $display("FAIL simul_once: got %0d entries expected 1 entry of addr 00", d_acc.size());
        else n_pass++;
        repeat (5) tick();
        n_total++;
        if (d_acc.size() < 2 || d_acc[1] !== 8'h80)
            $display("FAIL simul_next: got %0d entries expected second addr %h", d_acc.size(), 8'h80);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        fetchEnable = 1'b1; instrReady = 1'b1;
        parallelFlag = 1'b1; parallelAddress = 8'hFE;
        tick();
        parallelFlag = 1'b0;
        repeat (8) tick();
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (k >= d_acc.size() || d_acc[k] !== 8'hFE + 8'(k))
                $display("FAIL wrap_%0d: got %h expected %h", k, (k < d_acc.size()) ? d_acc[k] : 8'hXX, 8'hFE + 8'(k));
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        fetchEnable = 1'b1; instrReady = 1'b0;
        repeat (8) tick();
        n_total++;
        if (readyFlag !== 1'b1) $display("FAIL mid_full: got %b expected %b", readyFlag, 1'b1);
        else n_pass++;
        rst = 1'b0;
        tick();
        rst = 1'b1; fetchEnable = 1'b0;
        #1;
        n_total++;
        if ({readyFlag, memRead, memAddress} !== 10'h0)
            $display("FAIL mid_reset: got %h expected %h", {readyFlag, memRead, memAddress}, 10'h0);
        else n_pass++;
        fetchEnable = 1'b1;
        d_reads = 0;
        tick();
        fetchEnable = 1'b0;
        tick();
        n_total++;
        if ({memRead, readyFlag, instrAddress, instructionOutput} !== {1'b0, 1'b1, 8'h00, 32'hA5000000})
            $display("FAIL mid_inflight: got %h expected %h",
                     {memRead, readyFlag, instrAddress, instructionOutput}, {1'b0, 1'b1, 8'h00, 32'hA5000000});
        else n_pass++;
        tick();
        n_total++;
        if (d_reads !== 1) $display("FAIL mid_reads: got %0d expected %0d", d_reads, 1);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst             = ($urandom_range(0, 59) != 0);
            fetchEnable     = ($urandom_range(0, 7) != 0);
            parallelFlag    = ($urandom_range(0, 15) == 0);
            parallelAddress = 8'($urandom);
            instrReady      = ($urandom_range(0, 3) != 0);
            tick();
            n_total++;
            if (dut_vec() !== exp_vec()) $display("FAIL rand_c%0d: got %h expected %h", c, dut_vec(), exp_vec());
            else n_pass++;
        end
        n_total++;
        if (d_acc.size() != m_acc.size())
            $display("FAIL rand_count: got %0d expected %0d", d_acc.size(), m_acc.size());
        else n_pass++;
        for (int k = 0; k < d_acc.size() && k < m_acc.size(); k++) begin
            if (d_acc[k] !== m_acc[k]) begin
                n_total++;
                $display("FAIL rand_acc_%0d: got %h expected %h", k, d_acc[k], m_acc[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_simultaneous();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
